// File: rtl/cam_capture_pkg.sv
// Shared definitions for the camera capture path, frame buffer and VGA reader:
// screen geometry defaults, capture FSM states and the RGB565 -> RGB332 bit map.
package cam_capture_pkg;

  localparam int SCREEN_WIDTH_DEF  = 176;
  localparam int SCREEN_HEIGHT_DEF = 144;

  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    IN_VS   = 2'd1,
    ACTIVE  = 2'd2
  } cap_state_t;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  // Keep the top bits of each channel: R[15:13], G[10:8], B[4:3].
  function automatic logic [7:0] to_rgb332(input rgb565_t px);
    return {px.r[4:2], px.g[5:3], px.b[4:3]};
  endfunction

endpackage

// File: rtl/cam_capture_rgb.sv
// Combinational colour reduction of one RGB565 pixel (high/low byte) to RGB332.
module rgb565_to_rgb332
  import cam_capture_pkg::*;
(
  input  logic [7:0] i_hi,
  input  logic [7:0] i_lo,
  output logic [7:0] o_pix
);

  rgb565_t w_px;
  logic    w_unused;

  assign w_px     = rgb565_t'({i_hi, i_lo});
  assign o_pix    = to_rgb332(w_px);
  assign w_unused = ^{i_hi[4:3], i_lo[7:5], i_lo[2:0]};

endmodule

// File: rtl/cam_capture.sv
// OV7670-style capture: frames delimited by VSYNC, rows by HREF, two RGB565
// bytes per pixel reduced to RGB332 and written with registered X/Y addresses.
module cam_capture
  import cam_capture_pkg::*;
#(
  parameter int SCREEN_WIDTH  = SCREEN_WIDTH_DEF,
  parameter int SCREEN_HEIGHT = SCREEN_HEIGHT_DEF
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       VSYNC,
  input  logic       HREF,
  input  logic [7:0] DATA,
  output logic [7:0] PIXEL_OUT,
  output logic [7:0] X_ADDR,
  output logic [7:0] Y_ADDR,
  output logic       W_EN,
  output logic       FRAME_DONE
);

  localparam logic [7:0] W_LIM = 8'(SCREEN_WIDTH);
  localparam logic [7:0] H_LIM = 8'(SCREEN_HEIGHT);

  cap_state_t r_state;
  logic       r_phase;
  logic       r_href_q;
  logic [7:0] r_hi;
  logic [7:0] r_x;
  logic [7:0] r_y;
  logic [7:0] r_pix;
  logic [7:0] r_xaddr;
  logic [7:0] r_yaddr;
  logic       r_wen;
  logic       r_frame_done;
  logic [7:0] w_pix;

  rgb565_to_rgb332 u_rgb (
    .i_hi  (r_hi),
    .i_lo  (DATA),
    .o_pix (w_pix)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state      <= WAIT_VS;
      r_phase      <= 1'b0;
      r_href_q     <= 1'b0;
      r_hi         <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_pix        <= '0;
      r_xaddr      <= '0;
      r_yaddr      <= '0;
      r_wen        <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_wen        <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        WAIT_VS: begin
          if (VSYNC) r_state <= IN_VS;
        end
        IN_VS: begin
          if (!VSYNC) begin
            r_state  <= ACTIVE;
            r_phase  <= 1'b0;
            r_href_q <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
          end
        end
        ACTIVE: begin
          // VSYNC wins over any HREF activity in the same cycle.
          if (VSYNC) begin
            r_state      <= IN_VS;
            r_frame_done <= 1'b1;
            r_phase      <= 1'b0;
            r_href_q     <= 1'b0;
            r_x          <= '0;
          end else begin
            r_href_q <= HREF;
            if (HREF) begin
              r_phase <= ~r_phase;
              if (!r_phase) begin
                r_hi <= DATA;
              end else begin
                if (r_x < W_LIM && r_y < H_LIM) begin
                  r_wen   <= 1'b1;
                  r_pix   <= w_pix;
                  r_xaddr <= r_x;
                  r_yaddr <= r_y;
                end
                if (r_x != W_LIM) r_x <= r_x + 8'd1;
              end
            end else begin
              // Clearing the phase here discards a dangling high byte.
              r_phase <= 1'b0;
              if (r_href_q) begin
                r_x <= '0;
                if (r_y != H_LIM) r_y <= r_y + 8'd1;
              end
            end
          end
        end
        default: r_state <= WAIT_VS;
      endcase
    end
  end

  assign PIXEL_OUT  = r_pix;
  assign X_ADDR     = r_xaddr;
  assign Y_ADDR     = r_yaddr;
  assign W_EN       = r_wen;
  assign FRAME_DONE = r_frame_done;

endmodule

// File: tb/tb_cam_capture.sv
// Randomized bench for cam_capture: a frame/row-level model predicts every
// write (cycle, pixel, address) and every FRAME_DONE; a monitor compares.
module tb_cam_capture;

  localparam int W = 176;
  localparam int H = 144;

  logic       CLK   = 1'b0;
  logic       RST_N = 1'b0;
  logic       VSYNC = 1'b0;
  logic       HREF  = 1'b0;
  logic [7:0] DATA  = '0;
  logic [7:0] PIXEL_OUT, X_ADDR, Y_ADDR;
  logic       W_EN, FRAME_DONE;

  cam_capture #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .VSYNC      (VSYNC),
    .HREF       (HREF),
    .DATA       (DATA),
    .PIXEL_OUT  (PIXEL_OUT),
    .X_ADDR     (X_ADDR),
    .Y_ADDR     (Y_ADDR),
    .W_EN       (W_EN),
    .FRAME_DONE (FRAME_DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         stamp;
    logic [7:0] pix;
    logic [7:0] x;
    logic [7:0] y;
  } wr_t;

  wr_t        exp_q[$];
  int         done_q[$];
  logic [7:0] dq[$];
  int         edge_n   = 0;
  int         n_checks = 0;
  int         n_fail   = 0;
  int         wr_cnt   = 0;
  int         done_cnt = 0;
  logic [7:0] last_x   = '0;
  logic [7:0] last_y   = '0;
  bit         mon_en   = 1'b0;
  bit         m_active = 1'b0;
  int         m_row    = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  // Colour reduction in channel terms: top 3 of R5, top 3 of G6, top 2 of B5.
  function automatic logic [7:0] ref_rgb332(input logic [7:0] hi, input logic [7:0] lo);
    logic [15:0] p;
    logic [4:0]  r5, b5;
    logic [5:0]  g6;
    p  = {hi, lo};
    r5 = p[15:11];
    g6 = p[10:5];
    b5 = p[4:0];
    return {r5[4:2], g6[5:3], b5[4:3]};
  endfunction

  task automatic step(input logic v, input logic h, input logic [7:0] d);
    VSYNC = v;
    HREF  = h;
    DATA  = d;
    @(posedge CLK);
    edge_n++;
    #1;
  endtask

  // One HREF window of nbytes followed by gap idle cycles.
  task automatic row(input int nbytes, input int gap);
    logic [7:0] hi, d;
    wr_t        e;
    hi = '0;
    for (int i = 0; i < nbytes; i++) begin
      d = (dq.size() > 0) ? dq.pop_front() : 8'($urandom);
      if (i % 2 == 0) begin
        hi = d;
      end else if (m_active && (i / 2) < W && m_row < H) begin
        e.stamp = edge_n + 1;
        e.pix   = ref_rgb332(hi, d);
        e.x     = 8'(i / 2);
        e.y     = 8'(m_row);
        exp_q.push_back(e);
      end
      step(1'b0, 1'b1, d);
    end
    for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 8'($urandom));
    if (m_active && nbytes > 0) m_row++;
  endtask

  // VSYNC high for len cycles (first cycle may carry HREF), then one idle cycle.
  task automatic vsync_pulse(input int len, input logic h);
    for (int i = 0; i < len; i++) begin
      if (i == 0) begin
        if (m_active) done_q.push_back(edge_n + 1);
        m_active = 1'b0;
      end
      step(1'b1, (i == 0) ? h : 1'b0, 8'($urandom));
    end
    step(1'b0, 1'b0, 8'h00);
    m_active = 1'b1;
    m_row    = 0;
  endtask

  always @(negedge CLK) begin
    bit  exp_w, exp_d;
    wr_t e;
    if (mon_en) begin
      exp_w = (exp_q.size() > 0) && (exp_q[0].stamp == edge_n);
      exp_d = (done_q.size() > 0) && (done_q[0] == edge_n);
      check_eq("w_en", 32'(W_EN), 32'(exp_w));
      if (exp_w) begin
        e = exp_q.pop_front();
        check_eq("pixel_out", 32'(PIXEL_OUT), 32'(e.pix));
        check_eq("x_addr", 32'(X_ADDR), 32'(e.x));
        check_eq("y_addr", 32'(Y_ADDR), 32'(e.y));
      end
      check_eq("frame_done", 32'(FRAME_DONE), 32'(exp_d));
      if (exp_d) void'(done_q.pop_front());
      if (W_EN) begin
        wr_cnt++;
        last_x = X_ADDR;
        last_y = Y_ADDR;
      end
      if (FRAME_DONE) done_cnt++;
    end
  end

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_pixel"}, 32'(PIXEL_OUT), 32'h0);
    check_eq({tag, "_x"}, 32'(X_ADDR), 32'h0);
    check_eq({tag, "_y"}, 32'(Y_ADDR), 32'h0);
    check_eq({tag, "_wen"}, 32'(W_EN), 32'h0);
    check_eq({tag, "_done"}, 32'(FRAME_DONE), 32'h0);
  endtask

  initial begin
    int base_w, base_d;

    RST_N = 1'b0;
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'hA5);
    check_zero_outputs("reset");
    RST_N  = 1'b1;
    mon_en = 1'b1;

    // HREF before any VSYNC must be ignored.
    row(6, 2);
    vsync_pulse(2, 1'b0);

    // Known colour pairs in one window.
    dq = '{8'hFF, 8'hE0, 8'h07, 8'hFF, 8'hF8, 8'h00, 8'h00, 8'h1F};
    row(8, 8);

    // Over-wide rows saturate X; following rows restart at X=0, Y+1.
    row(360, 8);
    row(10, 4);
    row(3, 2);
    row(600, 3);

    // Mid-row VSYNC with HREF high: row aborted, one FRAME_DONE.
    row(5, 0);
    vsync_pulse(2, 1'b1);

    // Full-size frame.
    base_w = wr_cnt;
    base_d = done_cnt;
    for (int r = 0; r < H; r++) row(352, 8);
    vsync_pulse(2, 1'b0);
    step(1'b0, 1'b0, 8'h00);
    check_eq("frame_writes", 32'(wr_cnt - base_w), 32'd25344);
    check_eq("frame_last_x", 32'(last_x), 32'd175);
    check_eq("frame_last_y", 32'(last_y), 32'd143);
    check_eq("frame_done_cnt", 32'(done_cnt - base_d), 32'd1);

    // Random lengths, odd counts and gaps; then enough rows to saturate Y.
    for (int r = 0; r < 6; r++) row(int'($urandom_range(0, 400)), int'($urandom_range(1, 8)));
    for (int r = 0; r < 150; r++) row(int'($urandom_range(0, 14)), int'($urandom_range(1, 4)));
    vsync_pulse(int'($urandom_range(1, 3)), 1'b0);

    // Reset during row 50 discards the frame until the next full VSYNC pulse.
    for (int r = 0; r < 50; r++) row(4, 2);
    row(3, 0);
    RST_N = 1'b0;
    step(1'b0, 1'b1, 8'hC3);
    RST_N    = 1'b1;
    m_active = 1'b0;
    check_zero_outputs("midrst");
    for (int r = 0; r < 3; r++) row(4, 2);
    vsync_pulse(3, 1'b0);
    for (int r = 0; r < 3; r++) row(int'($urandom_range(2, 20)), 2);
    check_eq("post_rst_y", 32'(last_y), 32'd2);
    vsync_pulse(2, 1'b0);

    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00);
    check_eq("exp_writes_left", 32'(exp_q.size()), 32'd0);
    check_eq("exp_done_left", 32'(done_q.size()), 32'd0);
    mon_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cam_capture.md
CAM_CAPTURE -- requirements
Module: cam_capture

Interface
REQ-001 Parameter SCREEN_WIDTH, default 176, pixels per row to store.
REQ-002 Parameter SCREEN_HEIGHT, default 144, rows per frame to store.
REQ-003 CLK  input  1  single clock; camera outputs are launched and sampled on its rising edge.
REQ-004 RST_N  input  1  reset, synchronous and active-low.
REQ-005 VSYNC  input  1  frame sync, high for 1+ cycles before each frame.
REQ-006 HREF  input  1  row valid, high while pixel bytes are presented.
REQ-007 DATA  input  8  pixel byte stream, RGB565, high byte first.
REQ-008 PIXEL_OUT  output  8  RGB332 pixel for the frame buffer.
REQ-009 X_ADDR  output  8  column of PIXEL_OUT, 0..SCREEN_WIDTH-1.
REQ-010 Y_ADDR  output  8  row of PIXEL_OUT, 0..SCREEN_HEIGHT-1.
REQ-011 W_EN  output  1  one-cycle write strobe qualifying PIXEL_OUT/X_ADDR/Y_ADDR.
REQ-012 FRAME_DONE  output  1  one-cycle pulse at frame end.

Function
REQ-013 The FSM SHALL have states WAIT_VS (await VSYNC high), IN_VS (await VSYNC low), ACTIVE (capture rows).
REQ-014 WAIT_VS->IN_VS on VSYNC=1; IN_VS->ACTIVE on VSYNC=0; ACTIVE->IN_VS on VSYNC=1, pulsing FRAME_DONE the next cycle.
REQ-015 In ACTIVE, each HREF=1 cycle SHALL consume one byte; a byte-phase bit alternates high/low, cleared when HREF=0.
REQ-016 On a high-byte cycle DATA SHALL be latched into an 8-bit holding register.
REQ-017 On a low-byte cycle the pixel SHALL be {hi[7:5], hi[2:0], DATA[4:3]} (R[15:13], G[10:8], B[4:3]).
REQ-018 Latency: W_EN and PIXEL_OUT SHALL assert the cycle after the low byte is sampled, addressed to the current column and row.
REQ-019 X SHALL increment after each assembled pixel and reset to 0 on the HREF 1->0 edge.
REQ-020 Y SHALL increment on each HREF 1->0 edge in ACTIVE and reset to 0 on entry to ACTIVE.
REQ-021 Pixels with X>=SCREEN_WIDTH or Y>=SCREEN_HEIGHT SHALL be dropped (W_EN=0); X and Y saturate and never wrap.
REQ-022 A high byte with HREF falling before its low byte SHALL be discarded and no write issued.
REQ-023 VSYNC=1 during an active row SHALL abort the row and take priority over any HREF activity that cycle.
REQ-024 HREF in WAIT_VS or IN_VS SHALL be ignored.
REQ-025 W_EN, FRAME_DONE SHALL be low in every cycle not specified above.

Reset
REQ-026 RST_N=0 at a clock edge SHALL force WAIT_VS, byte phase 0, X=0, Y=0, holding register 0, PIXEL_OUT=0, X_ADDR=0, Y_ADDR=0, W_EN=0, FRAME_DONE=0.
REQ-027 Reset mid-frame SHALL discard the partial frame; capture resumes only after the next complete VSYNC pulse.

Structure
REQ-028 SCREEN_WIDTH/SCREEN_HEIGHT defaults, FSM state encodings and the RGB565->RGB332 bit map SHALL reside in a shared package used with the frame buffer and VGA reader.
REQ-029 The colour reduction SHALL be a combinational sub-module rgb565_to_rgb332; all else stays flat.

Verification
REQ-030 Bytes 0xFF,0xE0 in one HREF window after VSYNC -> one W_EN with PIXEL_OUT=0xFC, X_ADDR=0, Y_ADDR=0.
REQ-031 Bytes 0x07,0xFF -> PIXEL_OUT=0x1F; 0xF8,0x00 -> 0xE0; 0x00,0x1F -> 0x03.
REQ-032 Frame of 144 rows, 352 bytes each, 8-cycle HREF gaps, VSYNC high 2 cycles -> exactly 25344 W_EN, last at X=175,Y=143, one FRAME_DONE on next VSYNC.
REQ-033 Row of 360 bytes (180 pixels) -> writes X=0..175 only; next row starts X=0, Y+1.
REQ-034 RST_N low for 1 cycle at row 50 -> all outputs 0 next cycle; no W_EN until after the following VSYNC pulse, then Y restarts at 0.
REQ-035 HREF high for 3 bytes then low -> one W_EN, dangling byte dropped; VSYNC asserted mid-row -> row aborted, FRAME_DONE pulses once.
